multdiv_scheduler: RTL and testbench

//  Sequences the shared multi-cycle multdiv unit for the 5-stage pipeline.

---
 rtl/mds_pkg.sv | 24 ++
 rtl/mds_if.sv | 47 ++++
 rtl/mds_watchdog.sv | 40 ++++
 rtl/multdiv_scheduler.sv | 163 ++++++++++++++++
 tb/tb_multdiv_scheduler.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mds_pkg.sv
// Shared definitions for the multdiv scheduler: state encoding, exception
// status codes, the watchdog abort value and a status-code helper.
package mds_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    WB    = 2'd3
  } mds_state_e;

  localparam int unsigned MDS_EXC_REG      = 30;
  localparam int unsigned MDS_MULT_CODE    = 4;
  localparam int unsigned MDS_DIV_CODE     = 5;
  localparam logic [31:0] MDS_TIMEOUT_DATA = 32'hFFFF_FFFF;

  // Status value reported in the exception register for a faulting op.
  function automatic int unsigned exc_code(input logic        is_mult,
                                           input int unsigned mult_code,
                                           input int unsigned div_code);
    return is_mult ? mult_code : div_code;
  endfunction

endpackage

// File: rtl/mds_if.sv
// Bundle of issue, multdiv-unit and writeback signals around the scheduler.
// master = scheduler side, slave = pipeline/multdiv/regfile side.
interface mds_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) ();

  logic              issue_valid;
  logic              issue_mult;
  logic              issue_div;
  logic [REG_W-1:0]  issue_rd;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic              issue_ready;
  logic              flush;

  logic              md_mult;
  logic              md_div;
  logic [DATA_W-1:0] md_a;
  logic [DATA_W-1:0] md_b;
  logic              md_ready;
  logic              md_exc;
  logic [DATA_W-1:0] md_result;

  logic              w_we;
  logic              wb_we;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;

  logic              stall;
  logic              timeout;

  modport master (
    input  issue_valid, issue_mult, issue_div, issue_rd, issue_a, issue_b, flush,
    input  md_ready, md_exc, md_result, w_we,
    output issue_ready, md_mult, md_div, md_a, md_b,
    output wb_we, wb_reg, wb_data, stall, timeout
  );

  modport slave (
    output issue_valid, issue_mult, issue_div, issue_rd, issue_a, issue_b, flush,
    output md_ready, md_exc, md_result, w_we,
    input  issue_ready, md_mult, md_div, md_a, md_b,
    input  wb_we, wb_reg, wb_data, stall, timeout
  );

endinterface

// File: rtl/mds_watchdog.sv
// Busy-cycle watchdog for the multdiv scheduler; the module only exists when
// MDS_WATCHDOG_EN is defined. expire is high in the LIMIT-th enabled cycle.
`ifdef MDS_WATCHDOG_EN
module mds_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expire = enable && (count_q == CW'(LIMIT - 1));

  // Saturate once expired; the scheduler leaves BUSY on that same edge.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/multdiv_scheduler.sv
// Sequences one mult/div through the shared multdiv unit and arbitrates the
// regfile write port with the W stage. Optional watchdog: MDS_WATCHDOG_EN.
module multdiv_scheduler
  import mds_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned EXC_REG   = MDS_EXC_REG,
  parameter int unsigned MULT_CODE = MDS_MULT_CODE,
  parameter int unsigned DIV_CODE  = MDS_DIV_CODE
`ifdef MDS_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_CYC  = 64
`endif
) (
  input  logic   clock,
  input  logic   reset,
  mds_if.master  bus
);

  mds_state_e        state_q,   state_d;
  logic              op_mult_q, op_mult_d;
  logic [REG_W-1:0]  rd_q,      rd_d;
  logic [DATA_W-1:0] md_a_q,    md_a_d;
  logic [DATA_W-1:0] md_b_q,    md_b_d;
  logic [REG_W-1:0]  wb_reg_q,  wb_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic md_mult;
  logic md_div;
  logic wb_we;
  logic wdog_expire;

`ifdef MDS_WATCHDOG_EN
  logic timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    op_mult_d = op_mult_q;
    rd_d      = rd_q;
    md_a_d    = md_a_q;
    md_b_d    = md_b_q;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    md_mult   = 1'b0;
    md_div    = 1'b0;
    wb_we     = 1'b0;
`ifdef MDS_WATCHDOG_EN
    timeout_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // A malformed issue (both or neither op bit) is consumed as a no-op.
        if (bus.issue_valid && (bus.issue_mult ^ bus.issue_div)) begin
          op_mult_d = bus.issue_mult;
          rd_d      = bus.issue_rd;
          md_a_d    = bus.issue_a;
          md_b_d    = bus.issue_b;
          state_d   = START;
        end
      end

      START, BUSY: begin
        if (state_q == START) begin
          md_mult = op_mult_q;
          md_div  = !op_mult_q;
        end
        // A result already present during START is taken as if in BUSY.
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.md_ready) begin
          if (bus.md_exc) begin
            wb_reg_d  = REG_W'(EXC_REG);
            wb_data_d = DATA_W'(exc_code(op_mult_q, MULT_CODE, DIV_CODE));
          end else begin
            wb_reg_d  = rd_q;
            wb_data_d = bus.md_result;
          end
          state_d = WB;
        end else if (wdog_expire) begin
          wb_reg_d  = REG_W'(EXC_REG);
          wb_data_d = DATA_W'(MDS_TIMEOUT_DATA);
          state_d   = WB;
`ifdef MDS_WATCHDOG_EN
          timeout_d = 1'b1;
`endif
        end else begin
          state_d = BUSY;
        end
      end

      WB: begin
        // The W stage owns the port when it wants it; $0 is never written.
        if (wb_reg_q == '0) begin
          state_d = IDLE;
        end else if (!bus.w_we) begin
          wb_we   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_mult_q <= 1'b0;
      rd_q      <= '0;
      md_a_q    <= '0;
      md_b_q    <= '0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_mult_q <= op_mult_d;
      rd_q      <= rd_d;
      md_a_q    <= md_a_d;
      md_b_q    <= md_b_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

`ifdef MDS_WATCHDOG_EN
  mds_watchdog #(
    .LIMIT (WDOG_CYC)
  ) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q == START),
    .enable (state_q == BUSY),
    .expire (wdog_expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wdog_expire = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.issue_ready = (state_q == IDLE);
  assign bus.stall       = (state_q != IDLE);
  assign bus.md_mult     = md_mult;
  assign bus.md_div      = md_div;
  assign bus.md_a        = md_a_q;
  assign bus.md_b        = md_b_q;
  assign bus.wb_we       = wb_we;
  assign bus.wb_reg      = wb_reg_q;
  assign bus.wb_data     = wb_data_q;

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Scoreboard bench for multdiv_scheduler: directed scenarios plus random ops;
// expected start pulses and regfile writes are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_multdiv_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b0;

  mds_if #(.DATA_W(32), .REG_W(5)) bus ();

`ifdef MDS_WATCHDOG_EN
  multdiv_scheduler #(.WDOG_CYC(8)) dut (.clock(clock), .reset(reset), .bus(bus));
`else
  multdiv_scheduler dut (.clock(clock), .reset(reset), .bus(bus));
`endif

  always #5 clock = ~clock;

  typedef struct { logic is_mult; logic [31:0] a; logic [31:0] b; } start_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;

  start_t start_q[$];
  wr_t    wr_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input logic [127:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every start pulse and every scheduler write must match the model.
  always @(negedge clock) begin
    if (reset) begin
      if (bus.md_mult || bus.md_div) begin
        if (start_q.size() == 0) begin
          fail_event("start_unexpected", {bus.md_mult, bus.md_div});
        end else begin
          start_t s;
          s = start_q.pop_front();
          check("start_op", {bus.md_mult, bus.md_div}, s.is_mult ? 2'b10 : 2'b01);
          check("start_a", bus.md_a, s.a);
          check("start_b", bus.md_b, s.b);
          $display("start  op=%s a=%08h b=%08h", bus.md_mult ? "mult" : "div", bus.md_a, bus.md_b);
        end
      end
      if (bus.wb_we) begin
        check("wb_port_free", bus.w_we, 1'b0);
        if (wr_q.size() == 0) begin
          fail_event("wb_unexpected", {bus.wb_reg, bus.wb_data});
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wb_reg", bus.wb_reg, w.rd);
          check("wb_data", bus.wb_data, w.data);
          $display("write  $%0d = %08h", bus.wb_reg, bus.wb_data);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.issue_valid = 1'b0; bus.issue_mult = 1'b0; bus.issue_div = 1'b0;
    bus.issue_rd = '0; bus.issue_a = '0; bus.issue_b = '0; bus.flush = 1'b0;
    bus.md_ready = 1'b0; bus.md_exc = 1'b0; bus.md_result = '0; bus.w_we = 1'b0;
  endtask

  task automatic issue(input logic m, input logic d, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    bus.issue_valid = 1'b1; bus.issue_mult = m; bus.issue_div = d;
    bus.issue_rd = rd; bus.issue_a = a; bus.issue_b = b;
    tick();
    bus.issue_valid = 1'b0;
    bus.issue_a = $urandom;
    bus.issue_b = $urandom;
    if (m ^ d) start_q.push_back('{m, a, b});
  endtask

  // One op: result arrives lat cycles after the start cycle; W stage holds
  // the port for wcyc cycles of WB; flush_at >= 0 flushes that many cycles in.
  task automatic do_op(input logic m, input logic d, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input int lat,
                       input logic exc, input logic [31:0] res, input int wcyc,
                       input int flush_at);
    logic [4:0]  dest;
    logic [31:0] data;
    $display("op     m=%0d d=%0d rd=%0d lat=%0d exc=%0d wcyc=%0d flush_at=%0d",
             m, d, rd, lat, exc, wcyc, flush_at);
    issue(m, d, rd, a, b);
    if (!(m ^ d)) begin
      check("noop_stall", bus.stall, 1'b0);
      return;
    end
    for (int k = 0; k < lat; k++) begin
      check("busy_stall", bus.stall, 1'b1);
      if (k == flush_at) begin
        bus.issue_valid = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_idle", bus.stall, 1'b0);
        bus.md_ready = 1'b1; bus.md_exc = 1'($urandom_range(0, 1)); bus.md_result = $urandom;
        tick();
        bus.md_ready = 1'b0; bus.md_exc = 1'b0;
        check("late_ready_ignored", bus.stall, 1'b0);
        return;
      end
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_mult = 1'b1; bus.issue_div = 1'b0;
      tick();
    end
    bus.issue_valid = 1'b0;
    dest = exc ? 5'd30 : rd;
    data = exc ? (m ? 32'd4 : 32'd5) : res;
    if (dest != 5'd0) wr_q.push_back('{dest, data});
    bus.md_ready = 1'b1; bus.md_exc = exc; bus.md_result = res;
    tick();
    bus.md_ready = 1'b0; bus.md_exc = 1'b0;
    check("wb_stall", bus.stall, 1'b1);
    for (int k = 0; k < wcyc; k++) begin
      bus.w_we = 1'b1;
      tick();
    end
    bus.w_we = 1'b0;
    tick();
    check("wb_release", bus.stall, 1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {bus.md_mult, bus.md_div, bus.wb_we, bus.stall, bus.timeout,
                 bus.md_a, bus.md_b, bus.wb_reg, bus.wb_data}, 128'd0);
    check({name, "_ready"}, bus.issue_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int sel, lat, wcyc, fl;
    logic m, d, exc;
    logic [4:0] rd;

    clear_inputs();
    #2;
    check_reset_outputs("reset_state");
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Mult $5 = 6*7 with the result four cycles after the start cycle.
    do_op(1'b1, 1'b0, 5'd5, 32'd6, 32'd7, 4, 1'b0, 32'd42, 0, -1);
    // Div exception: status 5 goes to $30.
    do_op(1'b0, 1'b1, 5'd3, 32'd100, 32'd0, 2, 1'b1, 32'hDEAD_BEEF, 0, -1);
    // W stage owns the port for three WB cycles.
    do_op(1'b1, 1'b0, 5'd12, 32'd9, 32'd9, 1, 1'b0, 32'd81, 3, -1);
    // Flush in BUSY, then a late result.
    do_op(1'b0, 1'b1, 5'd8, 32'd50, 32'd5, 4, 1'b0, 32'd10, 0, 2);
    // Malformed issues and a $0 destination.
    do_op(1'b1, 1'b1, 5'd7, 32'd1, 32'd2, 1, 1'b0, 32'd3, 0, -1);
    do_op(1'b0, 1'b0, 5'd7, 32'd1, 32'd2, 1, 1'b0, 32'd3, 0, -1);
    do_op(1'b1, 1'b0, 5'd0, 32'd1, 32'd2, 0, 1'b0, 32'd3, 2, -1);

    // Reset in the middle of BUSY.
    $display("op     reset mid-BUSY");
    issue(1'b1, 1'b0, 5'd6, 32'd6, 32'd11);
    tick();
    tick();
    check("pre_reset_stall", bus.stall, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_busy");
    tick();
    reset = 1'b1;
    tick();
    do_op(1'b0, 1'b1, 5'd21, 32'd77, 32'd7, 3, 1'b0, 32'd11, 0, -1);

`ifdef MDS_WATCHDOG_EN
    $display("op     watchdog abort");
    issue(1'b1, 1'b0, 5'd9, 32'd3, 32'd4);
    wr_q.push_back('{5'd30, 32'hFFFF_FFFF});
    for (int k = 0; k < 9; k++) begin
      check("wdog_pre_timeout", bus.timeout, 1'b0);
      tick();
    end
    check("timeout_pulse", bus.timeout, 1'b1);
    tick();
    check("timeout_single", bus.timeout, 1'b0);
    check("timeout_release", bus.stall, 1'b0);
`else
    $display("op     long BUSY without watchdog");
    issue(1'b0, 1'b1, 5'd4, 32'd8, 32'd2);
    for (int k = 0; k < 80; k++) tick();
    check("no_wdog_stall", bus.stall, 1'b1);
    check("no_wdog_timeout", bus.timeout, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("no_wdog_flush", bus.stall, 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin m = 1'b1; d = 1'b1; end
      else if (sel == 1) begin m = 1'b0; d = 1'b0; end
      else begin m = 1'(sel % 2); d = !m; end
      rd   = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) rd = 5'd0;
      lat  = $urandom_range(0, 6);
      exc  = ($urandom_range(0, 4) == 0);
      wcyc = $urandom_range(0, 3);
      fl   = (lat > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, lat - 1) : -1;
      do_op(m, d, rd, $urandom, $urandom, lat, exc, $urandom, wcyc, fl);
    end

    tick();
    tick();
    check("start_drain", start_q.size(), 0);
    check("write_drain", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
